// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, the decode-side
// instruction stream, and the redirect input from the branch unit.
interface instr_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   // Fetch unit side.
   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
      redirect_valid, redirect_pc
   );

   // Memory and decode side.
   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
      redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word fetches, tags them with their PC, and
// buffers in-order responses for decode. On a redirect, responses still in flight are dropped.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.master bus
);
   localparam int            CW      = $clog2(DEPTH + 1);
   localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);

   // Handshakes: a request transfers in a cycle where imem_req_valid and
   // imem_req_ready are both high; an instruction transfers when instr_valid and
   // instr_ready are both high; imem_rsp_valid is always accepted.

   logic [31:0]   pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] outstanding_next;
   logic [31:0]   tag_mem  [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [AW-1:0] tag_wr, tag_rd, fifo_wr, fifo_rd;

   logic req_valid, req_fire, rsp, fifo_push, fifo_pop, instr_valid;

   wire unused_redirect_low = &{1'b0, bus.redirect_pc[1:0]};

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      req_valid        = ~rst & (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W);
      req_fire         = req_valid & bus.imem_req_ready;
      rsp              = bus.imem_rsp_valid;
      instr_valid      = (fifo_count != '0) & ~bus.redirect_valid;
      fifo_push        = rsp & (drop_cnt == '0) & ~bus.redirect_valid;
      fifo_pop         = instr_valid & bus.instr_ready;
      outstanding_next = outstanding + CW'(req_fire) - CW'(rsp);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= {RESET_PC[31:2], 2'b00};
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_count  <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         fifo_wr     <= '0;
         fifo_rd     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_mem[i]  <= '0;
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else begin
         outstanding <= outstanding_next;
         // The tag queue tracks every in-flight request, including ones a redirect has orphaned.
         if (req_fire) begin
            tag_mem[tag_wr] <= pc;
            tag_wr          <= ptr_inc(tag_wr);
         end
         if (rsp) tag_rd <= ptr_inc(tag_rd);

         if (bus.redirect_valid) begin
            pc         <= {bus.redirect_pc[31:2], 2'b00};
            drop_cnt   <= outstanding_next;
            fifo_count <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
         end else begin
            if (req_fire) pc <= pc + 32'd4;
            if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            if (fifo_push) begin
               data_mem[fifo_wr] <= bus.imem_rsp_data;
               pc_mem[fifo_wr]   <= tag_mem[tag_rd];
               fifo_wr           <= ptr_inc(fifo_wr);
            end
            if (fifo_pop) fifo_rd <= ptr_inc(fifo_rd);
            case ({fifo_push, fifo_pop})
               2'b10:   fifo_count <= fifo_count + CW'(1);
               2'b01:   fifo_count <= fifo_count - CW'(1);
               default: ;
            endcase
         end
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc;
   assign bus.instr_valid    = instr_valid;
   assign bus.instr          = data_mem[fifo_rd];
   assign bus.instr_pc       = pc_mem[fifo_rd];

   // Request throttling keeps the buffer from ever overflowing; responses never exceed requests.
   assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_count == FULL));
   assert property (@(posedge clk) disable iff (rst) !(rsp && outstanding == '0));
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, checked against a
// transaction-level model of in-flight fetches and buffered instructions.
module tb_instr_fetch;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_if bus ();
   instr_fetch_if bus_w ();

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut   (.clk(clk), .rst(rst), .bus(bus));
   instr_fetch #(.RESET_PC(WRAP_PC),  .DEPTH(3))     dut_w (.clk(clk), .rst(rst), .bus(bus_w));

   int tests = 0;
   int fails = 0;
   int cyc, accepts, first_acc_cyc, first_del_cyc, n0;
   int p_ready, p_rsp, p_iready, p_redir;

   logic [31:0] model_pc;
   logic [31:0] infl_q[$];
   bit          stale_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] mem_q[$];
   logic [31:0] acc_q[$];
   logic [31:0] del_q[$];

   bit          w_pend, aux_rec;
   logic [31:0] w_pend_addr;
   logic [31:0] w_addr_q[$];
   logic [31:0] w_pc_q[$];
   logic [31:0] w_instr_q[$];
   int          w_cyc_q[$];

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F69;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string t);
      check({t, "_req_valid"},   32'(bus.imem_req_valid), 32'd0);
      check({t, "_instr_valid"}, 32'(bus.instr_valid),    32'd0);
      check({t, "_req_addr"},    bus.imem_req_addr,       RESET_PC);
      check({t, "_instr"},       bus.instr,               32'd0);
      check({t, "_instr_pc"},    bus.instr_pc,            32'd0);
      check({t, "_w_req_addr"},  bus_w.imem_req_addr,     WRAP_PC);
   endtask

   task automatic drive_inputs();
      bus.imem_req_ready = ($urandom_range(99) < p_ready);
      bus.imem_rsp_valid = (mem_q.size() != 0) && ($urandom_range(99) < p_rsp);
      bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_fn(mem_q[0]) : $urandom;
      bus.instr_ready    = ($urandom_range(99) < p_iready);
      bus.redirect_valid = ($urandom_range(99) < p_redir);
      bus.redirect_pc    = $urandom;
      bus_w.imem_req_ready = 1'b1;
      bus_w.instr_ready    = 1'b1;
      bus_w.imem_rsp_valid = w_pend;
      bus_w.imem_rsp_data  = mem_fn(w_pend_addr);
      bus_w.redirect_valid = 1'b0;
      bus_w.redirect_pc    = 32'd0;
   endtask

   // Reset entry: stray responses and redirects are driven and must be ignored.
   task automatic do_reset();
      rst = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0040;
      bus_w.imem_req_ready = 1'b0;
      bus_w.instr_ready    = 1'b0;
      bus_w.imem_rsp_valid = 1'b0;
      bus_w.imem_rsp_data  = 32'd0;
      bus_w.redirect_valid = 1'b0;
      bus_w.redirect_pc    = 32'd0;
      infl_q.delete(); stale_q.delete(); exp_q.delete(); exp_pc_q.delete();
      mem_q.delete(); acc_q.delete(); del_q.delete();
      model_pc = RESET_PC;
      accepts = 0; first_acc_cyc = -1; first_del_cyc = -1; cyc = 0;
      w_pend = 1'b0; w_pend_addr = 32'd0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("rst");
      rst = 1'b0;
      drive_inputs();
   endtask

   task automatic observe();
      bit exp_rv, exp_iv, fire, rsp, pop, redir, s;
      logic [31:0] a;
      @(negedge clk);
      cyc++;
      exp_rv = (infl_q.size() + exp_q.size()) < DEPTH;
      exp_iv = (exp_q.size() != 0) && !bus.redirect_valid;
      check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("req_addr", bus.imem_req_addr, model_pc);
      check("instr_valid", 32'(bus.instr_valid), 32'(exp_iv));
      if (exp_iv) begin
         check("instr",    bus.instr,    exp_q[0]);
         check("instr_pc", bus.instr_pc, exp_pc_q[0]);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         acc_q.push_back(bus.imem_req_addr);
         accepts++;
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (bus.instr_valid && bus.instr_ready) begin
         del_q.push_back(bus.instr_pc);
         if (first_del_cyc < 0) first_del_cyc = cyc;
      end

      fire  = exp_rv && bus.imem_req_ready;
      rsp   = bus.imem_rsp_valid;
      pop   = exp_iv && bus.instr_ready;
      redir = bus.redirect_valid;
      if (pop) begin
         void'(exp_q.pop_front());
         void'(exp_pc_q.pop_front());
      end
      if (fire) begin
         infl_q.push_back(model_pc);
         stale_q.push_back(1'b0);
         mem_q.push_back(model_pc);
         model_pc = model_pc + 32'd4;
      end
      if (rsp && infl_q.size() != 0) begin
         a = infl_q.pop_front();
         s = stale_q.pop_front();
         void'(mem_q.pop_front());
         if (!s && !redir) begin
            exp_q.push_back(mem_fn(a));
            exp_pc_q.push_back(a);
         end
      end
      if (redir) begin
         foreach (stale_q[i]) stale_q[i] = 1'b1;
         exp_q.delete();
         exp_pc_q.delete();
         model_pc = {bus.redirect_pc[31:2], 2'b00};
      end

      if (aux_rec) begin
         if (bus_w.imem_req_valid) w_addr_q.push_back(bus_w.imem_req_addr);
         if (bus_w.instr_valid) begin
            w_pc_q.push_back(bus_w.instr_pc);
            w_instr_q.push_back(bus_w.instr);
            w_cyc_q.push_back(cyc);
         end
      end
      w_pend      = bus_w.imem_req_valid;
      w_pend_addr = bus_w.imem_req_addr;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         observe();
         @(posedge clk);
         #1;
         drive_inputs();
      end
   endtask

   initial begin
      // Streaming at full rate; the aux instance covers wrap-around and steady throughput.
      p_ready = 100; p_rsp = 100; p_iready = 100; p_redir = 0;
      aux_rec = 1'b1;
      do_reset();
      run(12);
      aux_rec = 1'b0;
      check("acc_cnt", 32'(acc_q.size() >= 3), 32'd1);
      if (acc_q.size() >= 3) begin
         check("acc0", acc_q[0], 32'h0);
         check("acc1", acc_q[1], 32'h4);
         check("acc2", acc_q[2], 32'h8);
      end
      check("first_latency", 32'(first_del_cyc - first_acc_cyc), 32'd2);
      check("del_cnt", 32'(del_q.size() >= 1), 32'd1);
      if (del_q.size() >= 1) check("first_del_pc", del_q[0], 32'h0);
      check("w_acc_cnt", 32'(w_addr_q.size() >= 3), 32'd1);
      if (w_addr_q.size() >= 3) begin
         check("w_acc0", w_addr_q[0], 32'hFFFF_FFFC);
         check("w_acc1", w_addr_q[1], 32'h0000_0000);
         check("w_acc2", w_addr_q[2], 32'h0000_0004);
      end
      check("w_del_cnt", 32'(w_pc_q.size() >= 4), 32'd1);
      if (w_pc_q.size() >= 4) begin
         check("w_pc0",    w_pc_q[0],    32'hFFFF_FFFC);
         check("w_pc1",    w_pc_q[1],    32'h0000_0000);
         check("w_pc3",    w_pc_q[3],    32'h0000_0008);
         check("w_instr0", w_instr_q[0], mem_fn(32'hFFFF_FFFC));
         check("w_first_cyc", 32'(w_cyc_q[0]), 32'd3);
         check("w_back2back", 32'(w_cyc_q[3] - w_cyc_q[0]), 32'd3);
      end

      // Decode stalled: the fetch window fills and requests stop until a pop.
      p_iready = 0;
      do_reset();
      run(8);
      check("hold_accepts", 32'(accepts), 32'd2);
      check("hold_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("hold_head_pc", bus.instr_pc, 32'h0);
      p_iready = 100;
      bus.instr_ready = 1'b1;
      run(4);
      check("resume_cnt", 32'(acc_q.size() >= 3), 32'd1);
      if (acc_q.size() >= 3) check("resume_addr", acc_q[2], 32'h8);

      // Redirect with two fetches in flight and an unaligned target.
      p_ready = 100; p_rsp = 0; p_iready = 100;
      do_reset();
      run(3);
      check("redir_outstanding", 32'(accepts), 32'd2);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      n0 = acc_q.size();
      p_rsp = 100;
      run(1);
      run(10);
      check("redir_acc_cnt", 32'(acc_q.size() > n0), 32'd1);
      if (acc_q.size() > n0) check("redir_addr", acc_q[n0], 32'h0000_0100);
      check("redir_del_cnt", 32'(del_q.size() >= 1), 32'd1);
      if (del_q.size() >= 1) check("redir_first_pc", del_q[0], 32'h0000_0100);

      // Redirect in the same cycle as a request handshake and a response.
      do_reset();
      run(1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      run(1);
      run(10);
      check("same_acc_cnt", 32'(acc_q.size() >= 2), 32'd1);
      if (acc_q.size() >= 2) check("same_acc1", acc_q[1], 32'h4);
      check("same_del_cnt", 32'(del_q.size() >= 1), 32'd1);
      if (del_q.size() >= 1) check("same_first_pc", del_q[0], 32'h0000_0200);

      // Reset asserted between clock edges with two fetches in flight.
      p_rsp = 0;
      do_reset();
      run(3);
      check("mid_outstanding", 32'(accepts), 32'd2);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async");
      p_rsp = 100;
      do_reset();
      run(8);
      check("restart_acc_cnt", 32'(acc_q.size() >= 1), 32'd1);
      if (acc_q.size() >= 1) check("restart_addr", acc_q[0], RESET_PC);
      check("restart_del_cnt", 32'(del_q.size() >= 1), 32'd1);
      if (del_q.size() >= 1) check("restart_first_pc", del_q[0], RESET_PC);

      // Randomized traffic with occasional, then frequent, redirects.
      p_ready = 75; p_rsp = 60; p_iready = 65; p_redir = 4;
      do_reset();
      run(3000);
      p_ready = 90; p_rsp = 90; p_iready = 80; p_redir = 20;
      run(1000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: maximum number of in-flight requests plus buffered instructions.
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  response valid; always accepted, no backpressure.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port instr_valid  output  1  instruction available to the decode stage.
REQ-011 SHALL have port instr_ready  input  1  decode stage consumes the instruction.
REQ-012 SHALL have port instr  output  32  instruction word, driving op/funct3/funct7_5 decode.
REQ-013 SHALL have port instr_pc  output  32  address of instr.
REQ-014 SHALL have port redirect_valid  input  1  taken JAL/JALR/branch; flush and refetch.
REQ-015 SHALL have port redirect_pc  input  32  new fetch target.

Function
REQ-016 SHALL hold fetch PC register pc; imem_req_addr = pc; pc[1:0] always 2'b00, with redirect_pc[1:0] discarded.
REQ-017 SHALL assert imem_req_valid when not in reset and outstanding + fifo_count < DEPTH; it SHALL NOT depend on redirect_valid.
REQ-018 SHALL, on a request handshake (valid & ready), push pc into a DEPTH-entry tag queue, increment outstanding, and set pc := pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL keep imem_req_addr stable while imem_req_valid is high and imem_req_ready is low, unless redirect_valid is high.
REQ-020 SHALL assume in-order responses, exactly one per accepted request, arriving at least 1 cycle after acceptance.
REQ-021 SHALL, on imem_rsp_valid, pop the tag queue and decrement outstanding; if drop_cnt > 0 it SHALL discard the data and decrement drop_cnt, otherwise push {data, tag} into the instruction FIFO.
REQ-022 SHALL use a registered FIFO: a response in cycle M gives instr_valid high in cycle M+1 at the earliest, so an accepted request in cycle N gives an instruction no earlier than cycle N+2.
REQ-023 SHALL drive instr_valid = (fifo_count != 0) & ~redirect_valid, with instr/instr_pc taken from the FIFO head; pop on instr_valid & instr_ready.
REQ-024 SHALL, when redirect_valid is high: clear the FIFO; set drop_cnt := outstanding after this cycle's request/response accounting, so a request accepted this cycle is counted and a response arriving this cycle is discarded; set pc := {redirect_pc[31:2], 2'b00}.
REQ-025 SHALL give redirect priority over a same-cycle FIFO push, pop, and pc increment.
REQ-026 SHALL, on a second redirect while drop_cnt > 0, recompute drop_cnt per REQ-024. Only the last target is fetched.
REQ-027 SHALL handle simultaneous push and pop with count unchanged; the FIFO SHALL never overflow (guaranteed by REQ-017), and a push into a full FIFO is a design error flagged by assertion.
REQ-028 SHALL implement outstanding and drop_cnt as counters of width clog2(DEPTH+1); neither SHALL underflow.

Reset
REQ-029 SHALL, while rst is high, force pc = RESET_PC, outstanding = 0, drop_cnt = 0, FIFO and tag queue empty, imem_req_valid = 0, instr_valid = 0, imem_req_addr = RESET_PC, instr = 0, and instr_pc = 0.
REQ-030 SHALL ignore imem_rsp_valid and redirect_valid while rst is high; the memory is reset by the same rst, so no stale responses exist afterwards.
REQ-031 SHALL allow the first request in the first clock edge after rst deasserts; reset asserted mid-operation SHALL abandon all in-flight state immediately.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory, instr_ready=1 -> addresses 0,4,8... each accepted; instr_pc 0 appears 2 cycles after the first accept; then one instruction per cycle.
REQ-033 instr_ready=0 with DEPTH=2 -> exactly 2 requests issued, FIFO holds pc 0 and 4, imem_req_valid stays 0 until a pop, then a request for 8.
REQ-034 Redirect to 32'h0000_0103 with 2 outstanding -> next request address is 0x100, both old responses discarded, first instr_pc = 0x100.
REQ-035 Redirect in the same cycle as a request handshake and a response -> that response is dropped, drop_cnt counts the new request, and no old-path instruction reaches the output.
REQ-036 RESET_PC = 32'hFFFF_FFFC -> fetch addresses FFFF_FFFC, 0000_0000, 0000_0004.
REQ-037 rst pulsed mid-stream with 2 outstanding -> outputs return to reset values asynchronously; after release, fetch restarts at RESET_PC with no stale instruction delivered.
